// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Holds the FSM state encoding, the digit type and the decimal-point masks.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [3:0] DP_SECONDS = 4'b0100;
    localparam logic [3:0] DP_LAP     = 4'b0101;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and
// rising-edge detector producing a one-cycle event pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          prev_q;

    // Level is accepted once the synchronized input has differed from it
    // for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CMAX) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit SS.CC BCD stopwatch feeding the 7-segment display driver.
// Optional lap hold is enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       fin,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_clr,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
`endif
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] dp_n,
    output logic       running,
    output logic       ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic            ss_ev;
    logic            clr_ev;
    sw_state_e       state_q;
    sw_state_e       state_d;
    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_d;
    bcd_t [3:0]      cnt_q;
    bcd_t [3:0]      cnt_d;
    bcd_t [3:0]      disp_q;
    logic [3:0]      dp_q;
    logic            running_q;
    logic            ovf_q;
    logic            ovf_d;
    logic            tick;
    logic            carry;
    logic            hold_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk_i  (fin),
        .rst_ni (rst_n),
        .btn_i  (btn_ss),
        .rise_o (ss_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk_i  (fin),
        .rst_ni (rst_n),
        .btn_i  (btn_clr),
        .rise_o (clr_ev)
    );

    // Clear wins over start/stop arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clr_ev) begin
            state_d = IDLE;
        end else if (ss_ev) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign tick = (state_q == RUN) && (pre_q == PMAX);

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        carry = 1'b1;
        if (clr_ev) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (carry) begin
                        cnt_d[i] = bcd_inc(cnt_q[i]);
                        carry    = (cnt_q[i] == 4'd9);
                    end
                end
                ovf_d = carry;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_ev;
    logic hold_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk_i  (fin),
        .rst_ni (rst_n),
        .btn_i  (btn_lap),
        .rise_o (lap_ev)
    );

    always_comb begin
        hold_d = hold_q;
        if (clr_ev || ss_ev) begin
            hold_d = 1'b0;
        end else if (lap_ev && (state_q == RUN)) begin
            hold_d = ~hold_q;
        end
    end

    always_ff @(posedge fin) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_d = 1'b0;
`endif

    always_ff @(posedge fin) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            dp_q      <= DP_SECONDS;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            disp_q    <= hold_d ? disp_q : cnt_d;
            dp_q      <= hold_d ? DP_LAP : DP_SECONDS;
            running_q <= (state_d == RUN);
            ovf_q     <= ovf_d;
        end
    end

    assign num1    = disp_q[3];
    assign num2    = disp_q[2];
    assign num3    = disp_q[1];
    assign num4    = disp_q[0];
    assign dp_n    = dp_q;
    assign running = running_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: a 10-cycle-tick instance for control
// behaviour and a 1-cycle-tick instance to reach the 99.99 wrap quickly.
module tb_bcd_stopwatch;

    localparam logic [3:0] DPS = 4'b0100;
    localparam logic [3:0] DPL = 4'b0101;

    typedef struct packed {
        int          due;
        logic [63:0] nm;
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        run;
        logic        ov;
    } exp_t;

    logic fin = 1'b0;
    logic rst_n;
    logic ss, clr, lap;
    logic fss, fclr, flap;
    logic [3:0] m_n1, m_n2, m_n3, m_n4, m_dp;
    logic [3:0] f_n1, f_n2, f_n3, f_n4, f_dp;
    logic m_run, m_ovf, f_run, f_ovf;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit bcd_bad = 1'b0;
    exp_t qm[$];
    exp_t qf[$];

    always #5 fin = ~fin;
    always @(posedge fin) cyc <= cyc + 1;

    bcd_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut (
        .fin(fin), .rst_n(rst_n), .btn_ss(ss), .btn_clr(clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap(lap),
`endif
        .num1(m_n1), .num2(m_n2), .num3(m_n3), .num4(m_n4),
        .dp_n(m_dp), .running(m_run), .ovf(m_ovf)
    );

    bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut_fast (
        .fin(fin), .rst_n(rst_n), .btn_ss(fss), .btn_clr(fclr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap(flap),
`endif
        .num1(f_n1), .num2(f_n2), .num3(f_n3), .num4(f_n4),
        .dp_n(f_dp), .running(f_run), .ovf(f_ovf)
    );

    task automatic step(input int n);
        repeat (n) @(posedge fin);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push(input bit fast, input int due, input logic [63:0] nm,
                        input int v, input logic [3:0] dp, input logic run,
                        input logic ov);
        exp_t e;
        e.due = due;
        e.nm  = nm;
        e.dig = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        e.dp  = dp;
        e.run = run;
        e.ov  = ov;
        if (fast) qf.push_back(e);
        else qm.push_back(e);
    endtask

    task automatic compare(input exp_t e, input logic [15:0] dig,
                           input logic [3:0] dp, input logic run, input logic ov);
        checks++;
        if (e.due != cyc || dig !== e.dig || dp !== e.dp || run !== e.run || ov !== e.ov) begin
            failures++;
            $display("FAIL %0s cyc=%0d due=%0d got dig=%h dp=%b run=%b ovf=%b want dig=%h dp=%b run=%b ovf=%b",
                     e.nm, cyc, e.due, dig, dp, run, ov, e.dig, e.dp, e.run, e.ov);
        end
    endtask

    always @(negedge fin) begin
        while (qm.size() > 0 && qm[0].due <= cyc)
            compare(qm.pop_front(), {m_n1, m_n2, m_n3, m_n4}, m_dp, m_run, m_ovf);
        while (qf.size() > 0 && qf[0].due <= cyc)
            compare(qf.pop_front(), {f_n1, f_n2, f_n3, f_n4}, f_dp, f_run, f_ovf);
        if (rst_n === 1'b1 && cyc > 1) begin
            if (m_n1 > 4'd9 || m_n2 > 4'd9 || m_n3 > 4'd9 || m_n4 > 4'd9 ||
                f_n1 > 4'd9 || f_n2 > 4'd9 || f_n3 > 4'd9 || f_n4 > 4'd9)
                bcd_bad = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p, r, x, y, r5, p6;
`ifdef STOPWATCH_LAP_EN
        int r7, l;
`endif
        ss = 0; clr = 0; lap = 0;
        fss = 0; fclr = 0; flap = 0;
        rst_n = 0;
        step(3);
        push(0, cyc, "rst", 0, DPS, 0, 0);
        push(1, cyc, "f_rst", 0, DPS, 0, 0);
        rst_n = 1;
        step(2);

        // start: RUN seven edges after the press edge
        p = cyc;
        ss = 1;
        r = p + 8;
        push(0, p + 7, "t1_pre", 0, DPS, 0, 0);
        push(0, r, "t1_run", 0, DPS, 1, 0);
        push(0, r + 9, "t1_t0", 0, DPS, 1, 0);
        push(0, r + 10, "t1_t1", 1, DPS, 1, 0);
        push(0, r + 99, "t1_009", 9, DPS, 1, 0);
        push(0, r + 100, "t1_010", 10, DPS, 1, 0);
        step(10);
        ss = 0;

        // pause with prescaler at 5, resume finishes the partial tick
        wait_until(r + 147);
        ss = 1;
        x = cyc + 8;
        push(0, x - 1, "t2_run", 15, DPS, 1, 0);
        push(0, x, "t2_pau", 15, DPS, 0, 0);
        push(0, x + 50, "t2_h1", 15, DPS, 0, 0);
        push(0, x + 150, "t2_h2", 15, DPS, 0, 0);
        step(10);
        ss = 0;
        wait_until(x + 200);
        ss = 1;
        y = cyc + 8;
        push(0, y - 1, "t2_pre", 15, DPS, 0, 0);
        push(0, y, "t2_res", 15, DPS, 1, 0);
        push(0, y + 4, "t2_y4", 15, DPS, 1, 0);
        push(0, y + 5, "t2_y5", 16, DPS, 1, 0);
        push(0, y + 15, "t2_y15", 17, DPS, 1, 0);
        step(10);
        ss = 0;

        // clear from RUN
        wait_until(y + 20);
        clr = 1;
        push(0, cyc + 7, "t3_pre", 18, DPS, 1, 0);
        push(0, cyc + 8, "t3_clr", 0, DPS, 0, 0);
        step(10);
        clr = 0;
        step(20);

        // bounce shorter than the debounce window
        push(0, cyc + 10, "bnc_a", 0, DPS, 0, 0);
        push(0, cyc + 40, "bnc_b", 0, DPS, 0, 0);
        for (int i = 0; i < 5; i++) begin
            ss = 1;
            step(2);
            ss = 0;
            step(2);
        end
        step(25);

        // start and clear together while running
        ss = 1;
        r5 = cyc + 8;
        push(0, r5, "t5_run", 0, DPS, 1, 0);
        step(10);
        ss = 0;
        wait_until(r5 + 35);
        p6 = cyc;
        ss = 1;
        clr = 1;
        push(0, p6 + 7, "t5_pre", 4, DPS, 1, 0);
        push(0, p6 + 8, "t5_clr", 0, DPS, 0, 0);
        push(0, p6 + 30, "t5_idl", 0, DPS, 0, 0);
        step(10);
        ss = 0;
        clr = 0;
        wait_until(p6 + 40);

`ifdef STOPWATCH_LAP_EN
        ss = 1;
        r7 = cyc + 8;
        step(10);
        ss = 0;
        wait_until(r7 + 297);
        lap = 1;
        l = cyc + 8;
        push(0, l - 1, "lap_pre", 30, DPS, 1, 0);
        push(0, l, "lap_on", 30, DPL, 1, 0);
        push(0, l + 49, "lap_hld", 30, DPL, 1, 0);
        step(10);
        lap = 0;
        wait_until(l + 42);
        lap = 1;
        push(0, l + 50, "lap_off", 35, DPS, 1, 0);
        step(10);
        lap = 0;
        clr = 1;
        push(0, cyc + 8, "lap_clr", 0, DPS, 0, 0);
        step(10);
        clr = 0;
        step(20);
`endif

        // wrap on the one-cycle-tick instance
        fss = 1;
        r = cyc + 8;
        push(1, r, "f_run", 0, DPS, 1, 0);
        push(1, r + 9998, "f_9998", 9998, DPS, 1, 0);
        push(1, r + 9999, "f_9999", 9999, DPS, 1, 0);
        push(1, r + 10000, "f_wrap", 0, DPS, 1, 1);
        push(1, r + 10001, "f_0001", 1, DPS, 1, 0);
        step(10);
        fss = 0;
        wait_until(r + 10003);
        step(2);

        checks++;
        if (qm.size() != 0 || qf.size() != 0) begin
            failures++;
            $display("FAIL pending got=%0d want=0", qm.size() + qf.size());
        end
        checks++;
        if (bcd_bad) begin
            failures++;
            $display("FAIL bcd_range got=non-BCD digit want=0..9");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
